// File: rtl/render_cmd_pkg.sv
// render_cmd_pkg
// Shared types and helpers for the renderer command sequencer.
//   seq_state_t   : sequencer states; each non-IDLE state names the register
//                   write currently being presented on the master port.
//   render_cmd_t  : packed draw command {y[8:0], x[9:0], tex[7:0]}.
//   REG_*         : renderer slave register indices.
//   next_write    : next write state after a completed write (skips are
//                   resolved here so skipped states take zero cycles).
//   write_addr / write_data : address and data presented in a given state.
package render_cmd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEX,
        S_NEGX,
        S_X,
        S_NEGY,
        S_Y,
        S_NEGCLR,
        S_PLOT
    } seq_state_t;

    typedef struct packed {
        logic [8:0] y;
        logic [9:0] x;
        logic [7:0] tex;
    } render_cmd_t;

    localparam int CMD_W = 27;

    localparam logic [3:0] REG_X    = 4'd1;
    localparam logic [3:0] REG_Y    = 4'd2;
    localparam logic [3:0] REG_NEG  = 4'd3;
    localparam logic [3:0] REG_TEX  = 4'd4;
    localparam logic [3:0] REG_PLOT = 4'd6;

    // neg is the renderer flag as it stands after the write just completed.
    function automatic seq_state_t next_write(input seq_state_t cur,
                                              input render_cmd_t cmd,
                                              input logic neg);
        seq_state_t nxt;
        nxt = S_IDLE;
        case (cur)
            S_TEX:    nxt = cmd.tex[7] ? S_PLOT : ((cmd.x[9] != neg) ? S_NEGX : S_X);
            S_NEGX:   nxt = S_X;
            S_X:      nxt = (cmd.y[8] != neg) ? S_NEGY : S_Y;
            S_NEGY:   nxt = S_Y;
            S_Y:      nxt = neg ? S_NEGCLR : S_PLOT;
            S_NEGCLR: nxt = S_PLOT;
            default:  nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] write_addr(input seq_state_t s);
        logic [3:0] a;
        case (s)
            S_TEX:                    a = REG_TEX;
            S_NEGX, S_NEGY, S_NEGCLR: a = REG_NEG;
            S_X:                      a = REG_X;
            S_Y:                      a = REG_Y;
            S_PLOT:                   a = REG_PLOT;
            default:                  a = 4'd0;
        endcase
        return a;
    endfunction

    // Magnitudes are taken modulo the field width, so -512 -> 512 and
    // -256 -> 256 come out correctly as unsigned values.
    function automatic logic [31:0] write_data(input seq_state_t s,
                                               input render_cmd_t cmd);
        logic [9:0]  mag_x;
        logic [8:0]  mag_y;
        logic [31:0] d;
        mag_x = cmd.x[9] ? (~cmd.x + 10'd1) : cmd.x;
        mag_y = cmd.y[8] ? (~cmd.y + 9'd1) : cmd.y;
        case (s)
            S_TEX:   d = {24'd0, cmd.tex};
            S_NEGX:  d = {31'd0, cmd.x[9]};
            S_X:     d = {22'd0, mag_x};
            S_NEGY:  d = {31'd0, cmd.y[8]};
            S_Y:     d = {23'd0, mag_y};
            default: d = 32'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/render_cmd_fifo.sv
// render_cmd_fifo
// Synchronous FIFO with registered pointers and occupancy count.
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data (ignored when full)
//   pop, rdata    : read request (ignored when empty), head-of-queue data
//   full, empty   : occupancy flags
module render_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer
// Buffers draw commands and replays each one as a sequence of Avalon-MM
// writes into the renderer register map.
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid/ready/data     : command input {y[8:0], x[9:0], tex[7:0]}
//   master_address/write/writedata, master_waitrequest : Avalon-MM master
//   busy                     : FIFO non-empty or sequencer active
//   cmds_done                : number of completed PLOT writes (wraps)
//
// state   | meaning
// IDLE    | no command in flight; pops the FIFO head into cmd_q
// TEX     | first cycle: present texture write; then hold until accepted
// NEGX    | flag write = sign(x), only entered when it differs from neg_q
// X       | x magnitude write
// NEGY    | flag write = sign(y), only entered when it differs from neg_q
// Y       | y magnitude write
// NEGCLR  | flag write = 0, only entered when neg_q is set
// PLOT    | plot trigger write; completion bumps cmds_done
module render_cmd_sequencer
    import render_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [26:0]      cmd_data,
    output logic [3:0]       master_address,
    output logic             master_write,
    output logic [31:0]      master_writedata,
    input  logic             master_waitrequest,
    output logic             busy,
    output logic [CNT_W-1:0] cmds_done
);

    seq_state_t         state_q, state_d, nxt;
    render_cmd_t        cmd_q, cmd_d;
    logic               neg_q, neg_d;
    logic               wr_q, wr_d;
    logic [3:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [CNT_W-1:0]   done_q, done_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]   fifo_rdata;
    logic               wr_done;

    render_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata (cmd_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready        = !fifo_full && !rst;
    assign busy             = !fifo_empty || (state_q != S_IDLE);
    assign master_address   = addr_q;
    assign master_write     = wr_q;
    assign master_writedata = data_q;
    assign cmds_done        = done_q;
    assign wr_done          = wr_q && !master_waitrequest;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        neg_d    = neg_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        fifo_pop = 1'b0;
        nxt      = S_IDLE;
        if (state_q == S_IDLE) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                cmd_d    = fifo_rdata;
                state_d  = S_TEX;
            end
        end else if (!wr_q) begin
            // Only TEX is entered without a write already on the bus.
            wr_d   = 1'b1;
            addr_d = write_addr(state_q);
            data_d = write_data(state_q, cmd_q);
        end else if (wr_done) begin
            if (addr_q == REG_NEG) neg_d = data_q[0];
            if (state_q == S_PLOT) done_d = done_q + {{(CNT_W-1){1'b0}}, 1'b1};
            // Present the next write on the same edge: no idle bus cycle.
            nxt     = next_write(state_q, cmd_q, neg_d);
            state_d = nxt;
            wr_d    = (nxt != S_IDLE);
            addr_d  = write_addr(nxt);
            data_d  = write_data(nxt, cmd_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            neg_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            neg_q   <= neg_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_render_cmd_sequencer.sv
module tb_render_cmd_sequencer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [26:0]      cmd_data;
    logic [3:0]       master_address;
    logic             master_write;
    logic [31:0]      master_writedata;
    logic             master_waitrequest;
    logic             busy;
    logic [CNT_W-1:0] cmds_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t log_q[$];

    render_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_data           (cmd_data),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .cmds_done          (cmds_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writes that will complete at the coming edge; c = edge that presented it.
    always @(negedge clk)
        if (master_write === 1'b1 && master_waitrequest === 1'b0)
            log_q.push_back('{master_address, master_writedata, cyc});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [26:0] mk(input logic [7:0] tex, input int x, input int y);
        logic [9:0] xx;
        logic [8:0] yy;
        xx = 10'(x);
        yy = 9'(y);
        return {yy, xx, tex};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the push edge.
    task automatic push(input logic [26:0] d, output int edge_cyc);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(posedge clk); #1;
        edge_cyc  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int idle_cyc);
        ok = 1'b0;
        idle_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                idle_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        master_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
        n_checks++; if (master_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b expected 0", master_write); end
        n_checks++; if (master_address !== 4'd0) begin n_fail++; $display("FAIL rst_address: got %0d expected 0", master_address); end
        n_checks++; if (master_writedata !== 32'd0) begin n_fail++; $display("FAIL rst_writedata: got %0h expected 0", master_writedata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (cmds_done !== 16'd0) begin n_fail++; $display("FAIL rst_cmds_done: got %0d expected 0", cmds_done); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_positive;
        logic [3:0]  ea[4] = '{4'd4, 4'd1, 4'd2, 4'd6};
        logic [31:0] ed[4] = '{32'h01, 32'd20, 32'd20, 32'd0};
        int pc, ic;
        bit ok;
        log_q.delete();
        push(mk(8'h01, 20, 20), pc);
        wait_idle(50, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pos_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 4) begin
            n_fail++; $display("FAIL pos_count: got %0d writes expected 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i] || log_q[i].c !== log_q[0].c + i) begin
                    n_fail++;
                    $display("FAIL pos_write%0d: got (%0d,%0h,c%0d) expected (%0d,%0h,c%0d)", i,
                             log_q[i].a, log_q[i].d, log_q[i].c, ea[i], ed[i], log_q[0].c + i);
                end
            end
            n_checks++; if (log_q[0].c !== pc + 2) begin n_fail++; $display("FAIL pos_latency: TEX presented at edge %0d expected %0d", log_q[0].c, pc + 2); end
            n_checks++; if (ic !== log_q[3].c + 1) begin n_fail++; $display("FAIL pos_busy_fall: busy low at edge %0d expected %0d", ic, log_q[3].c + 1); end
        end
        n_checks++; if (cmds_done !== 16'd1) begin n_fail++; $display("FAIL pos_cmds_done: got %0d expected 1", cmds_done); end
    endtask

    task automatic test_negative;
        logic [3:0]  ea[6] = '{4'd4, 4'd3, 4'd1, 4'd2, 4'd3, 4'd6};
        logic [31:0] ed[6] = '{32'h06, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0};
        int pc, ic;
        bit ok;
        log_q.delete();
        push(mk(8'h06, -1, -1), pc);
        wait_idle(50, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL neg_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 6) begin
            n_fail++; $display("FAIL neg_count: got %0d writes expected 6", log_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i] || log_q[i].c !== log_q[0].c + i) begin
                    n_fail++;
                    $display("FAIL neg_write%0d: got (%0d,%0h,c%0d) expected (%0d,%0h,c%0d)", i,
                             log_q[i].a, log_q[i].d, log_q[i].c, ea[i], ed[i], log_q[0].c + i);
                end
            end
        end
        n_checks++; if (cmds_done !== 16'd2) begin n_fail++; $display("FAIL neg_cmds_done: got %0d expected 2", cmds_done); end
    endtask

    task automatic test_fill;
        logic [3:0]  ea[2] = '{4'd4, 4'd6};
        logic [31:0] ed[2] = '{32'hFC, 32'd0};
        int pc, ic;
        bit ok;
        log_q.delete();
        push(mk(8'hFC, 5, 7), pc);
        wait_idle(50, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 2) begin
            n_fail++; $display("FAIL fill_count: got %0d writes expected 2", log_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i] || log_q[i].c !== log_q[0].c + i) begin
                    n_fail++;
                    $display("FAIL fill_write%0d: got (%0d,%0h,c%0d) expected (%0d,%0h,c%0d)", i,
                             log_q[i].a, log_q[i].d, log_q[i].c, ea[i], ed[i], log_q[0].c + i);
                end
            end
        end
        n_checks++; if (cmds_done !== 16'd3) begin n_fail++; $display("FAIL fill_cmds_done: got %0d expected 3", cmds_done); end
    endtask

    task automatic test_waitrequest_stall;
        logic [3:0]  ea[6] = '{4'd4, 4'd3, 4'd1, 4'd2, 4'd3, 4'd6};
        logic [31:0] ed[6] = '{32'h11, 32'd1, 32'd512, 32'd256, 32'd0, 32'd0};
        int pc, ic, rel_cyc;
        bit ok, seen;
        log_q.delete();
        master_waitrequest = 1'b1;
        push(mk(8'h11, -512, -256), pc);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (master_write) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_write_seen: write %b expected 1 within 10 cycles", master_write); end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (master_write !== 1'b1 || master_address !== 4'd4 || master_writedata !== 32'h11) begin
                n_fail++;
                $display("FAIL stall_stable%0d: got (%b,%0d,%0h) expected (1,4,11)", i,
                         master_write, master_address, master_writedata);
            end
        end
        n_checks++; if (log_q.size() != 0) begin n_fail++; $display("FAIL stall_no_complete: got %0d writes expected 0", log_q.size()); end
        master_waitrequest = 1'b0;
        rel_cyc = cyc;
        wait_idle(50, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 6) begin
            n_fail++; $display("FAIL stall_count: got %0d writes expected 6", log_q.size());
        end else begin
            n_checks++; if (log_q[0].c !== rel_cyc) begin n_fail++; $display("FAIL stall_release: TEX completed after edge %0d expected %0d", log_q[0].c, rel_cyc); end
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i]) begin
                    n_fail++;
                    $display("FAIL stall_write%0d: got (%0d,%0h) expected (%0d,%0h)", i,
                             log_q[i].a, log_q[i].d, ea[i], ed[i]);
                end
            end
        end
        n_checks++; if (cmds_done !== 16'd4) begin n_fail++; $display("FAIL stall_cmds_done: got %0d expected 4", cmds_done); end
    endtask

    task automatic test_fifo_full;
        int acc[$];
        int ic, k;
        bit ok;
        log_q.delete();
        master_waitrequest = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = mk(8'(32 + i), i + 1, 2 * i + 3);
            if (cmd_ready) acc.push_back(i);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_checks++; if (acc.size() != DEPTH + 1) begin n_fail++; $display("FAIL full_accepted: got %0d expected %0d", acc.size(), DEPTH + 1); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_cmd_ready: got %b expected 0", cmd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
        master_waitrequest = 1'b0;
        wait_idle(600, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 68) begin
            n_fail++; $display("FAIL full_count: got %0d writes expected 68", log_q.size());
        end else begin
            for (int j = 0; j < 17; j++) begin
                k = 4 * j;
                n_checks++;
                if (log_q[k].a !== 4'd4 || log_q[k].d !== 32'(32 + j) ||
                    log_q[k+1].a !== 4'd1 || log_q[k+1].d !== 32'(j + 1) ||
                    log_q[k+2].a !== 4'd2 || log_q[k+2].d !== 32'(2 * j + 3) ||
                    log_q[k+3].a !== 4'd6 || log_q[k+3].d !== 32'd0) begin
                    n_fail++;
                    $display("FAIL full_cmd%0d: got tex %0h x %0d y %0d plot %0d expected tex %0h x %0d y %0d plot 6", j,
                             log_q[k].d, log_q[k+1].d, log_q[k+2].d, log_q[k+3].a, 32 + j, j + 1, 2 * j + 3);
                end
            end
        end
        n_checks++; if (cmds_done !== 16'd21) begin n_fail++; $display("FAIL full_cmds_done: got %0d expected 21", cmds_done); end
    endtask

    task automatic test_reset_mid_write;
        logic [3:0]  ea[6] = '{4'd4, 4'd3, 4'd1, 4'd3, 4'd2, 4'd6};
        logic [31:0] ed[6] = '{32'h55, 32'd1, 32'd3, 32'd0, 32'd4, 32'd0};
        int pc, ic;
        bit ok, found;
        log_q.delete();
        master_waitrequest = 1'b1;
        push(mk(8'h33, -7, 9), pc);
        push(mk(8'h44, 1, 1), pc);
        master_waitrequest = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (master_write && master_address == 4'd1) begin
                found = 1'b1;
                master_waitrequest = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_x_seen: address %0d expected 1 within 20 cycles", master_address); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (master_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_write: got %b expected 0", master_write); end
        n_checks++; if (cmds_done !== 16'd0) begin n_fail++; $display("FAIL rstmid_cmds_done: got %0d expected 0", cmds_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_ready: got %b expected 0", cmd_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        master_waitrequest = 1'b0;
        log_q.delete();
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || log_q.size() != 0) begin n_fail++; $display("FAIL rstmid_fifo_empty: busy %b writes %0d expected 0 and 0", busy, log_q.size()); end
        push(mk(8'h55, -3, 4), pc);
        wait_idle(50, ok, ic);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_idle: busy still %b after budget", busy); end
        n_checks++;
        if (log_q.size() != 6) begin
            n_fail++; $display("FAIL rstmid_count: got %0d writes expected 6", log_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i]) begin
                    n_fail++;
                    $display("FAIL rstmid_write%0d: got (%0d,%0h) expected (%0d,%0h)", i,
                             log_q[i].a, log_q[i].d, ea[i], ed[i]);
                end
            end
        end
        n_checks++; if (cmds_done !== 16'd1) begin n_fail++; $display("FAIL rstmid_cmds_done: got %0d expected 1", cmds_done); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_fill();
        test_waitrequest_stall();
        test_fifo_full();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/render_cmd_sequencer.md
# render_cmd_sequencer

Upstream command stage for the renderer. It accepts packed draw commands (texture code plus signed midpoint) from the game-logic side through a valid/ready port and buffers them in a FIFO. For each command it runs an Avalon-MM master write sequence into the renderer's slave register map, honouring `waitrequest`. Software can then queue a whole frame of sprites without polling the renderer between plots.

## Interface
- `DEPTH`, 16: command FIFO depth; must be a power of two, at least 2.
- `CNT_W`, 16: width of the completed-command counter.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present on `cmd_data`.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_data`  in  27  `[7:0]` tex_code, `[17:8]` x (signed 10-bit), `[26:18]` y (signed 9-bit).
- `master_address`  out  4  renderer register index.
- `master_write`  out  1  write strobe.
- `master_writedata`  out  32  write data.
- `master_waitrequest`  in  1  renderer stall.
- `busy`  out  1  FIFO non-empty or sequencer not in IDLE.
- `cmds_done`  out  CNT_W  count of PLOT writes completed; wraps modulo 2^CNT_W.

## Operation
- Renderer register map:
  - 1 = x magnitude
  - 2 = y magnitude
  - 3 = negative-coordinate flag
  - 4 = tex_code
  - 6 = plot trigger
- The renderer applies the flag to x/y writes as they happen. The sequencer keeps a mirror `neg_q` of the renderer's flag; `neg_q` resets to 0.
- Fill command: `tex_code[7]=1`. Coordinates are ignored.
- States: IDLE, TEX, NEGX, X, NEGY, Y, NEGCLR, PLOT.
  - IDLE: if FIFO non-empty, pop into `cmd_q` and go to TEX.
  - TEX: write (4, zero-extended tex_code). Next state is PLOT for a fill command, otherwise NEGX.
  - NEGX: write (3, sign(x)) only if `sign(x) != neg_q`; otherwise pass through in 0 cycles straight to X.
  - X: write (1, |x|).
  - NEGY: same rule as NEGX, using sign(y).
  - Y: write (2, |y|).
  - NEGCLR: write (3, 0) only if `neg_q=1`; otherwise skip.
  - PLOT: write (6, 0), increment `cmds_done`, return to IDLE.
- `neg_q` updates on every completed register-3 write.
- Magnitudes are zero-extended to 32 bits. x = -512 produces 512.
- Commands are issued strictly in FIFO order. There is no reordering and no merging.

## Timing
- All master outputs are registered.
- A write completes on a rising edge where `master_write=1` and `master_waitrequest=0`. The state advances only on that edge.
- While `waitrequest=1`, `address`, `writedata` and `write` stay stable.
- The renderer holds `waitrequest` high while a plot is running. The next command's TEX write therefore stalls there; no extra handshake is needed.
- `cmd_ready = !full`; it is forced to 0 while `rst=1`. A push happens on `cmd_valid && cmd_ready`.
- There is no bypass path: a command pushed at edge N is popped at edge N+1, and its TEX write is presented from edge N+2.
- Back-to-back writes have no idle cycle between them. A positive-coordinate sprite takes 4 write cycles with zero wait states; a fill takes 2.
- A push and a pop in the same cycle are legal; occupancy stays the same.
- Throughput capacity is DEPTH entries in the FIFO plus one in `cmd_q`.
- Reset values:
  - `master_write`, `master_address`, `master_writedata`: 0
  - `cmds_done`: 0
  - `busy`: 0
  - FIFO: empty
  - `neg_q`: 0
  - state: IDLE
- Reset mid-transaction aborts the write immediately. The renderer must be reset in the same event so its flag matches `neg_q=0`.

## Structure
- Package `render_cmd_pkg` contains:
  - state enum `seq_state_t`
  - packed struct `render_cmd_t` (tex, x, y)
  - register constants `REG_X=1`, `REG_Y=2`, `REG_NEG=3`, `REG_TEX=4`, `REG_PLOT=6`
- Sub-module `render_cmd_fifo`: synchronous FIFO with registered pointers and count, and `full`/`empty` flags, parameterised by DEPTH and width.

## Test plan
- Push tex 0x01, x=20, y=20 -> writes (4,0x01), (1,20), (2,20), (6,0) with no address-3 write; `cmds_done`=1; `busy` falls 1 cycle later.
- Push tex 0x06, x=-1, y=-1 -> writes (4,0x06), (3,1), (1,1), (2,1), (3,0), (6,0); NEGY is skipped.
- Push fill tex 0xFC with x=5, y=7 -> writes (4,0xFC), (6,0) only.
- Hold `waitrequest` high for 50 cycles during the first write -> `write`, `address` and `data` stable for all 50 cycles; the write completes on the first low cycle.
- Hold `waitrequest` high and push 20 commands -> exactly DEPTH+1 = 17 accepted and `cmd_ready` low. After release, all 17 are issued in push order and `cmds_done`=17.
- Assert `rst` during an X write -> `master_write`=0 asynchronously, FIFO empty, `cmds_done`=0. After release, a new command issues with correct flag writes.
